// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, total derivations and sync polarities
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;
  // indices of the counter marks decoded on the next-state count
  localparam int M_LAST     = 0;
  localparam int M_ZERO     = 1;
  localparam int M_BLANK    = 2;
  localparam int M_SYNC_ON  = 3;
  localparam int M_SYNC_OFF = 4;
  localparam int M_NUM      = 5;
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic bit fits(input int total, input int w);
    return total <= (1 << w);
  endfunction
endpackage

// File: rtl/comparador_igual.sv
// comparador_igual: W-bit equality against a constant (bitwise XNOR, then AND-reduce)
module comparador_igual #(
  parameter int W = 10,
  parameter int VALUE = 0
) (
  input  logic [W-1:0] a,
  output logic         eq
);
  localparam logic [W-1:0] K = W'(VALUE);
  assign eq = &(a ~^ K);
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator with registered flags decoded from next-state counts
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HSYNC_POL = POL_LOW,
  parameter bit VSYNC_POL = POL_LOW,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             fim_h,
  output logic             fim_v,
  output logic             frame_start
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int H_MARKS [M_NUM] = '{H_TOTAL - 1, 0, H_ACTIVE, HS_START, HS_START + H_SYNC};
  localparam int V_MARKS [M_NUM] = '{V_TOTAL - 1, 0, V_ACTIVE, VS_START, VS_START + V_SYNC};
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      !fits(H_TOTAL, CNT_W) || !fits(V_TOTAL, CNT_W)) begin : g_bad_params
    $error("vga_sync_gen: zero porch/sync width or totals exceed CNT_W");
  end
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [M_NUM-1:0] h_hit, v_hit;
  logic h_vis, v_vis, h_vis_nxt, v_vis_nxt, hs_nxt, vs_nxt;
  for (genvar i = 0; i < M_NUM; i++) begin : g_marks
    comparador_igual #(.W(CNT_W), .VALUE(H_MARKS[i])) u_h (.a(h_nxt), .eq(h_hit[i]));
    comparador_igual #(.W(CNT_W), .VALUE(V_MARKS[i])) u_v (.a(v_nxt), .eq(v_hit[i]));
  end
  // counters step by one and restart at zero, so windows are tracked as set/clear on their edges
  always_comb begin
    h_nxt = pix_en ? (fim_h ? '0 : h_count + 1'b1) : h_count;
    v_nxt = (pix_en && fim_h) ? (fim_v ? '0 : v_count + 1'b1) : v_count;
    hs_nxt = h_hit[M_SYNC_ON] | ((hsync == HSYNC_POL) & ~h_hit[M_SYNC_OFF]);
    vs_nxt = v_hit[M_SYNC_ON] | ((vsync == VSYNC_POL) & ~v_hit[M_SYNC_OFF]);
    h_vis_nxt = h_hit[M_ZERO] | (h_vis & ~h_hit[M_BLANK]);
    v_vis_nxt = v_hit[M_ZERO] | (v_vis & ~v_hit[M_BLANK]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      h_vis <= 1'b1;
      v_vis <= 1'b1;
      video_on <= 1'b1;
      fim_h <= 1'b0;
      fim_v <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_count <= h_nxt;
      v_count <= v_nxt;
      hsync <= hs_nxt ? HSYNC_POL : ~HSYNC_POL;
      vsync <= vs_nxt ? VSYNC_POL : ~VSYNC_POL;
      h_vis <= h_vis_nxt;
      v_vis <= v_vis_nxt;
      video_on <= h_vis_nxt & v_vis_nxt;
      fim_h <= h_hit[M_LAST];
      fim_v <= v_hit[M_LAST];
      frame_start <= pix_en & fim_h & fim_v;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized checks of three timing modes against a tick-count reference model
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic ra = 1'b1, pa = 1'b0, rb = 1'b1, pb = 1'b0, rc = 1'b1, pc = 1'b0;
  logic ea, eb, ec;
  int na = 0, nb = 0, nc = 0, cyc_n = 0;
  int vec = 0, err = 0;
  logic [9:0] a_h, a_v, c_h, c_v;
  logic [3:0] b_h, b_v;
  logic a_hs, a_vs, a_vid, a_fh, a_fv, a_fs;
  logic b_hs, b_vs, b_vid, b_fh, b_fv, b_fs;
  logic c_hs, c_vs, c_vid, c_fh, c_fv, c_fs;
  logic [25:0] oa, ob, oc;
  assign oa = {a_h, a_v, a_hs, a_vs, a_vid, a_fh, a_fv, a_fs};
  assign ob = {6'd0, b_h, 6'd0, b_v, b_hs, b_vs, b_vid, b_fh, b_fv, b_fs};
  assign oc = {c_h, c_v, c_hs, c_vs, c_vid, c_fh, c_fv, c_fs};
  always #5 clk = ~clk;

  vga_sync_gen u_a (
    .clk(clk), .reset(ra), .pix_en(pa), .h_count(a_h), .v_count(a_v), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vid), .fim_h(a_fh), .fim_v(a_fv), .frame_start(a_fs));
  vga_sync_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)) u_b (
    .clk(clk), .reset(rb), .pix_en(pb), .h_count(b_h), .v_count(b_v), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vid), .fim_h(b_fh), .fim_v(b_fv), .frame_start(b_fs));
  vga_sync_gen #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_c (
    .clk(clk), .reset(rc), .pix_en(pc), .h_count(c_h), .v_count(c_v), .hsync(c_hs), .vsync(c_vs),
    .video_on(c_vid), .fim_h(c_fh), .fim_v(c_fv), .frame_start(c_fs));

  // expected outputs after n pixel ticks since reset; en says whether the last cycle ticked
  function automatic logic [25:0] model(input int mode, input int n, input logic en);
    int ha = 640, hf = 16, hw = 96, hb = 48, va = 480, vf = 10, vw = 2, vb = 33;
    logic ph = 1'b0, pv = 1'b0;
    int ht, vt, h, v;
    if (mode == 1) begin
      ha = 4; hf = 1; hw = 2; hb = 1; va = 3; vf = 1; vw = 1; vb = 1; ph = 1'b1; pv = 1'b1;
    end
    if (mode == 2) begin
      va = 8; vf = 2; vw = 2; vb = 3;
    end
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    h = n % ht;
    v = (n / ht) % vt;
    return {10'(h), 10'(v), (h >= ha + hf && h < ha + hf + hw) ? ph : ~ph,
            (v >= va + vf && v < va + vf + vw) ? pv : ~pv, h < ha && v < va,
            h == ht - 1, v == vt - 1, en && (n % (ht * vt) == 0)};
  endfunction

  task automatic cyc(input logic ar, input logic ae, input logic br, input logic be,
                     input logic cr, input logic ce);
    @(negedge clk);
    ra = ar; pa = ae; rb = br; pb = be; rc = cr; pc = ce;
    @(posedge clk);
    #1;
    ea = !ar && ae; eb = !br && be; ec = !cr && ce;
    na = ar ? 0 : na + int'(ae);
    nb = br ? 0 : nb + int'(be);
    nc = cr ? 0 : nc + int'(ce);
    cyc_n++;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 1, 1, 1, 1);
      vec += 3;
      if (oa !== model(0, 0, 0)) begin err++; $display("FAIL reset_a got=%h exp=%h", oa, model(0, 0, 0)); end
      if (ob !== model(1, 0, 0)) begin err++; $display("FAIL reset_b got=%h exp=%h", ob, model(1, 0, 0)); end
      if (oc !== model(2, 0, 0)) begin err++; $display("FAIL reset_c got=%h exp=%h", oc, model(2, 0, 0)); end
    end
  endtask

  task automatic test_random_line;
    for (int k = 0; k < 2000; k++) begin
      cyc(0, $urandom_range(0, 3) != 0, 0, 0, 0, 0);
      vec++;
      if (oa !== model(0, na, ea)) begin
        err++; $display("FAIL random_line cyc=%0d got=%h exp=%h", cyc_n, oa, model(0, na, ea));
      end
    end
  endtask

  task automatic test_alternate;
    int t1 = -1, t2 = -1;
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3400; k++) begin
      cyc(0, k % 2 == 0, 0, 0, 0, 0);
      vec++;
      if (oa !== model(0, na, ea)) begin
        err++; $display("FAIL alternate cyc=%0d got=%h exp=%h", cyc_n, oa, model(0, na, ea));
      end
      if (t1 < 0 && a_v == 10'd1 && a_h == 10'd0) t1 = k;
      if (t2 < 0 && a_v == 10'd2 && a_h == 10'd0) t2 = k;
    end
    vec++;
    if (t2 - t1 != 1600) begin err++; $display("FAIL line_span got=%0d exp=1600", t2 - t1); end
  endtask

  task automatic test_small_mode;
    int fs_at [$];
    cyc(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      cyc(0, 0, 0, $urandom_range(0, 1) != 0, 0, 0);
      vec++;
      if (ob !== model(1, nb, eb)) begin
        err++; $display("FAIL small_random cyc=%0d got=%h exp=%h", cyc_n, ob, model(1, nb, eb));
      end
    end
    cyc(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 200; k++) begin
      cyc(0, 0, 0, 1, 0, 0);
      vec++;
      if (ob !== model(1, nb, eb)) begin
        err++; $display("FAIL small_run cyc=%0d got=%h exp=%h", cyc_n, ob, model(1, nb, eb));
      end
      if (b_fs) fs_at.push_back(k);
    end
    vec++;
    if (fs_at.size() != 4) begin err++; $display("FAIL small_frames got=%0d exp=4", fs_at.size()); end
    for (int i = 1; i < fs_at.size(); i++) begin
      vec++;
      if (fs_at[i] - fs_at[i-1] != 48) begin
        err++; $display("FAIL small_frame_len got=%0d exp=48", fs_at[i] - fs_at[i-1]);
      end
    end
  endtask

  task automatic test_frames;
    int fs_cnt = 0;
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 24010; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      vec++;
      if (oc !== model(2, nc, ec)) begin
        err++; $display("FAIL frames cyc=%0d got=%h exp=%h", cyc_n, oc, model(2, nc, ec));
      end
      fs_cnt += int'(c_fs);
    end
    vec++;
    if (fs_cnt != 2) begin err++; $display("FAIL frame_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_mid_reset;
    int budget = 0;
    while (!(c_h == 10'd700 && c_v == 10'd5) && budget < 12000) begin
      cyc(0, 0, 0, 0, 0, 1);
      budget++;
    end
    vec++;
    if (budget >= 12000) begin err++; $display("FAIL mid_reset_reach got=%0d,%0d exp=700,5", c_h, c_v); end
    cyc(0, 0, 0, 0, 1, 1);
    vec++;
    if (oc !== model(2, 0, 0)) begin err++; $display("FAIL mid_reset got=%h exp=%h", oc, model(2, 0, 0)); end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, k[0]);
      vec++;
      if (oc !== model(2, nc, ec)) begin
        err++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc_n, oc, model(2, nc, ec));
      end
    end
  endtask

  initial begin
    test_reset;
    test_random_line;
    test_alternate;
    test_small_mode;
    test_frames;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA timing generator: horizontal and vertical pixel counters with wrap detection, sync pulse generation, active-video flag and frame strobe. It sits between the pixel-clock enable and the pixel pipeline, and supplies `h_count`/`v_count` coordinates and sync signals to the DAC/connector stage. It generalises the fixed 640x480 end-of-line compare (`h_count == 799`) to any mode chosen by parameters, and adds vertical counting, clock-enable gating and selectable sync polarity.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HSYNC_POL`, 0: active level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0: active level of `vsync`
- `CNT_W`, 10: counter width; requires 2^CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high
- `pix_en`  in  1  pixel tick; counters advance only on cycles where it is 1
- `h_count`  out  CNT_W  current column, 0..H_TOTAL-1
- `v_count`  out  CNT_W  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, at level `HSYNC_POL` when active
- `vsync`  out  1  vertical sync, at level `VSYNC_POL` when active
- `video_on`  out  1  high when `h_count < H_ACTIVE` and `v_count < V_ACTIVE`
- `fim_h`  out  1  high when `h_count == H_TOTAL-1` (level, not pulse)
- `fim_v`  out  1  high when `v_count == V_TOTAL-1` (level)
- `frame_start`  out  1  one-cycle pulse on entry to (0,0)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Counter behaviour when `pix_en`=1:
  - `h_count` increments; if `fim_h`, `h_count` becomes 0.
  - On that same cycle, `v_count` increments, or becomes 0 if `fim_v`.
- When `pix_en`=0, all state and all outputs hold.
- Sync windows:
  - hsync is active for `h_count` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751).
  - vsync is active for `v_count` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491).
  - vsync is line-based: it changes only on the wrap of `h_count`.
- `hsync`, `vsync`, `video_on`, `fim_h`, `fim_v` and `frame_start` are registered. Each is computed from the next-state counter values, so that it always describes the `h_count`/`v_count` currently presented. No combinational path runs from the counters to any output.
- `frame_start` asserts for exactly one `clk` cycle after a `pix_en` cycle that wraps both counters to (0,0). It does not assert on reset release.

## Timing
- Reset values:
  - `h_count`=0, `v_count`=0
  - `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL
  - `video_on`=1, `fim_h`=0, `fim_v`=0, `frame_start`=0
- `reset` takes priority over `pix_en`, including when asserted mid-frame. The next cycle shows the reset values.
- Latency: zero cycles between a counter value and its decoded flags, since both update on the same edge.
- If `pix_en` is tied to 1, one line is H_TOTAL `clk` cycles and one frame is H_TOTAL*V_TOTAL cycles.
- Simultaneous `fim_h` and `fim_v` with `pix_en`=1: both counters wrap on the same edge, and `frame_start` is high on the following cycle.
- Parameter check: elaboration fails if any porch or sync value is 0, or if a total does not fit in CNT_W.

## Structure
- Shared package `vga_pkg`:
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL derivation functions
  - polarity constants
- Sub-module `comparador_igual #(W, VALUE)`: a generic W-bit equality compare (bitwise XNOR, then AND-reduce). It is instantiated for the wrap and sync-edge decodes on the next-state counter values.
- One file per module.

## Test plan
- Default parameters, `pix_en`=1, run for 2 frames:
  - `fim_h` is high exactly at `h_count`=799.
  - The wrap 799→0 increments `v_count`.
  - `frame_start` pulses once every 420000 cycles.
- Default parameters:
  - `hsync`=0 exactly for `h_count` 656..751 on every line.
  - `vsync`=0 exactly for `v_count` 490..491.
  - `video_on`=0 at `h_count`=640 and at `v_count`=480.
- `pix_en` toggled 1/0 alternately:
  - Counters and all flags hold on 0 cycles.
  - A line spans 1600 `clk` cycles.
- Assert `reset` for 1 cycle at (h=700, v=300):
  - The next cycle shows h=0, v=0, `hsync`=1, `vsync`=1, `video_on`=1.
  - `frame_start` stays 0.
- Small mode with positive sync polarity:
  - Parameters: H=4/1/2/1, V=3/1/1/1, HSYNC_POL=VSYNC_POL=1, CNT_W=4.
  - H_TOTAL=8 and V_TOTAL=6.
  - `hsync`=1 at h=5..6 and `vsync`=1 at v=4.
  - A frame is 48 cycles.
- Hold `pix_en`=1 across the final pixel (799,524):
  - Both counters wrap on the same edge.
  - `fim_h` and `fim_v` deassert on that edge.
  - `frame_start` is high for exactly one cycle.
